// File: rtl/led_pattern_shifter.sv
// LED pattern engine: prescaled single-clock stepping with hold, rotate and bounce motion.
// Optional macro STEP_COUNT_EN adds a 16-bit step_count output.
module led_pattern_shifter #(
    parameter int              WIDTH         = 8,
    parameter int              CLK_HZ        = 50000000,
    parameter int              STEP_HZ       = 1,
    parameter logic [WIDTH-1:0] RESET_PATTERN = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic [1:0]       mode,
    input  logic             run,
    output logic [WIDTH-1:0] led,
    output logic             dir,
    output logic             step_tick
`ifdef STEP_COUNT_EN
    ,
    output logic [15:0]      step_count
`endif
);

    localparam int DIV   = CLK_HZ / STEP_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("led_pattern_shifter: CLK_HZ/STEP_HZ must be at least 2");
        end
    endgenerate

    logic [CNT_W-1:0] presc;
    logic             step;
    logic [WIDTH-1:0] led_nxt;
    logic             dir_nxt;

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], v[WIDTH-1]};
    endfunction

    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] v);
        return {v[0], v[WIDTH-1:1]};
    endfunction

    assign step = run && (presc == DIV_LAST);

    // Bounce reverses before shifting when the lit end has been reached.
    always_comb begin
        led_nxt = led;
        dir_nxt = dir;
        case (mode)
            2'b01: led_nxt = rotl(led);
            2'b10: led_nxt = rotr(led);
            2'b11: begin
                if (!dir && led[WIDTH-1]) begin
                    dir_nxt = 1'b1;
                    led_nxt = rotr(led);
                end else if (dir && led[0]) begin
                    dir_nxt = 1'b0;
                    led_nxt = rotl(led);
                end else if (dir) begin
                    led_nxt = rotr(led);
                end else begin
                    led_nxt = rotl(led);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            presc     <= '0;
            led       <= RESET_PATTERN;
            dir       <= 1'b0;
            step_tick <= 1'b0;
        end else if (load) begin
            presc     <= '0;
            led       <= load_data;
            dir       <= 1'b0;
            step_tick <= 1'b0;
        end else begin
            step_tick <= step;
            if (run) begin
                presc <= (presc == DIV_LAST) ? '0 : presc + CNT_W'(1);
            end
            if (step) begin
                led <= led_nxt;
                dir <= dir_nxt;
            end
        end
    end

`ifdef STEP_COUNT_EN
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            step_count <= '0;
        end else if (load) begin
            step_count <= '0;
        end else if (step) begin
            step_count <= step_count + 16'd1;
        end
    end
`endif

endmodule
